// File: rtl/pipelined_adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder/subtractor.
package pipelined_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Returns the per-stage chunk width, or 0 when the parameter pair is illegal.
  function automatic int chunk_width(input int width, input int stages);
    if (width < 2 || stages < 1) return 0;
    if ((width % stages) != 0) return 0;
    return width / stages;
  endfunction

endpackage

// File: rtl/pipelined_adder_chunk.sv
// Combinational C-bit ripple-carry slice built from single-bit full-adder cells.
module adder_fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ cin;
  assign co = (x & y) | (cin & (x ^ y));

endmodule

module adder_chunk
  import pipelined_adder_pkg::*;
#(
  parameter int C = 4
) (
  input  logic [C-1:0] x,
  input  logic [C-1:0] y,
  input  logic         cin,
  output logic [C-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [C:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < C; gi++) begin : g_bit
    adder_fa_cell u_fa (
      .x   (x[gi]),
      .y   (y[gi]),
      .cin (c[gi]),
      .s   (s[gi]),
      .co  (c[gi+1])
    );
  end

  assign co       = c[C];
  // Carry into the top bit; XORed with co it yields signed overflow.
  assign c_msb_in = c[C-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: one C-bit chunk resolved per register stage,
// with a single global advance enable driven by the output handshake.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int C = chunk_width(WIDTH, STAGES);

  if (C == 0) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             ovf_q;

  // Index k holds what stage k consumes; index STAGES is the output register view.
  logic [WIDTH-1:0] a_stg   [STAGES];
  logic [WIDTH-1:0] b_stg   [STAGES];
  logic             cmsb_stg[STAGES];
  logic [WIDTH-1:0] sum_stg [STAGES+1];
  logic             c_stg   [STAGES+1];
  logic             v_stg   [STAGES+1];

  assign out_valid = v_stg[STAGES];
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;

  assign b_eff   = (sub == MODE_SUB) ? ~b : b;
  assign cin_eff = (sub == MODE_SUB) ? 1'b1 : ci;

  assign a_stg[0]   = a;
  assign b_stg[0]   = b_eff;
  assign sum_stg[0] = '0;
  assign c_stg[0]   = cin_eff;
  assign v_stg[0]   = in_valid && in_ready;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [C-1:0]     s_c;
    logic             co_c;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             co_q;
    logic             v_q;

    adder_chunk #(.C(C)) u_chunk (
      .x        (a_stg[gi][gi*C +: C]),
      .y        (b_stg[gi][gi*C +: C]),
      .cin      (c_stg[gi]),
      .s        (s_c),
      .co       (co_c),
      .c_msb_in (cmsb_stg[gi])
    );

    always_comb begin
      sum_d              = sum_stg[gi];
      sum_d[gi*C +: C]   = s_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
        co_q  <= 1'b0;
        v_q   <= 1'b0;
      end else if (en) begin
        sum_q <= sum_d;
        co_q  <= co_c;
        v_q   <= v_stg[gi];
      end
    end

    assign sum_stg[gi+1] = sum_q;
    assign c_stg[gi+1]   = co_q;
    assign v_stg[gi+1]   = v_q;

    if (gi < STAGES - 1) begin : g_fwd
      // Operands travel alongside the partial sum so later stages see their chunks.
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_stg[gi];
          b_q <= b_stg[gi];
        end
      end

      assign a_stg[gi+1] = a_q;
      assign b_stg[gi+1] = b_q;
    end else begin : g_last
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= cmsb_stg[gi] ^ co_c;
        end
      end
    end
  end

  assign S    = sum_stg[STAGES];
  assign cout = c_stg[STAGES];
  assign ovf  = ovf_q;

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined ripple-carry adder/subtractor. It is the multi-bit, clocked successor to the team's single-bit full-adder cell. Operands of WIDTH bits are split into STAGES equal chunks, and each chunk is resolved in its own register stage, so throughput is one operation per cycle. A valid/ready handshake on both sides lets the block sit between datapath producers and consumers that may stall.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- STAGES, 2, pipeline stages; WIDTH % STAGES == 0 required (elaboration error otherwise); chunk width C = WIDTH/STAGES.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts beat this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in; used only when sub = 0.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- S  output  WIDTH  sum/difference.
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
- ovf  output  1  signed overflow.

## Operation
- Add: result = a + b + ci.
- Subtract: result = a + ~b + 1; ci ignored.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Global advance enable: en = !out_valid | out_ready. in_ready = en. All stage registers load only when en = 1.
- Stage k (0..STAGES-1):
  - Adds chunk k of a and the effective b (b or ~b), using carry from stage k-1's register; stage 0 uses the effective carry-in.
  - Registers its C-bit partial sum, its carry out, and the not-yet-consumed upper operand chunks.
  - Carries forward the lower sum chunks already produced.
- Per-stage valid bit shifts with en; it is loaded from in_valid & in_ready at stage 0. Bubbles propagate as valid = 0; stage data is don't-care when its valid = 0.
- Overflow: ovf = (carry into MSB) XOR (carry out of MSB), computed in the final stage.
- Outputs hold stable while out_valid & !out_ready.
- Wrap-around: results are modulo 2^WIDTH; the full carry appears on cout only.
- Simultaneous output transfer and input transfer in the same cycle is legal, and full throughput is kept.

## Timing
- Latency: STAGES cycles from input transfer to out_valid, absent stalls.
- Throughput: one operation per cycle while out_ready = 1.
- Backpressure: out_ready = 0 with out_valid = 1 freezes the entire pipe, in_ready drops combinationally in the same cycle, and no beat is lost or duplicated.
- in_ready depends combinationally on out_ready; there is no combinational path from a/b to in_ready.
- Reset, including mid-operation: all stage valids = 0, out_valid = 0, S = 0, cout = 0, ovf = 0, in_ready = 1. Beats in flight are discarded.
- First accept is allowed in the first cycle after rst_n deasserts.

## Structure
- Package pipelined_adder_pkg holds:
  - The mode encoding constants MODE_ADD = 1'b0 and MODE_SUB = 1'b1.
  - A function computing chunk width with the divisibility check.
- Sub-module adder_chunk is purely combinational: parameter C; inputs x, y, cin; outputs s, co, and c_msb_in, the carry into its top bit, needed for ovf.
  - It is instantiated once per stage and is built from full-adder bit cells.
- The top module holds only the stage registers, valid chain and handshake logic.

## Test plan
- Reset: assert rst_n = 0 mid-stream with 2 beats in flight -> out_valid = 0, S = 0, cout = 0, ovf = 0, in_ready = 1. No stale result emerges after release.
- Add, WIDTH = 8, STAGES = 2: a = 0xFF, b = 0x01, ci = 0 -> after 2 cycles S = 0x00, cout = 1, ovf = 0. Then a = 0x7F, b = 0x00, ci = 1 -> S = 0x80, cout = 0, ovf = 1.
- Subtract: a = 0x80, b = 0x01, sub = 1, ci = 1 (ignored) -> S = 0x7F, cout = 1, ovf = 1. Then a = 0x00, b = 0x01 -> S = 0xFF, cout = 0, ovf = 0.
- Throughput: 16 back-to-back beats, out_ready = 1 -> 16 consecutive out_valid cycles starting at cycle 2, results matching a reference model in order.
- Backpressure: random out_ready (50%) over 200 random beats with WIDTH = 32, STAGES = 4 -> every result is correct, in order, and held stable while stalled; in_ready == !out_valid | out_ready every cycle.
- Parameter corners: STAGES = 1 (latency 1) and STAGES = WIDTH (C = 1) -> same random stream gives correct results with latencies 1 and WIDTH.
